// File: rtl/packetmem_rd_port_pkg.sv
// Shared encodings for the packet-memory read responder.
// Transfer sizes, FSM states and the byte-count lookup.
package packetmem_rd_port_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_RSVD = 2'd3
    } xfer_sz_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_DATA0  = 3'd2,
        ST_DATA1  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Indexed by transfer_sz; the reserved code maps to zero bytes.
    localparam logic [3:0][2:0] NBYTES_LUT = {
        3'd0, 3'd1, 3'd2, 3'd4
    };

    function automatic logic [2:0] xfer_nbytes(
        input logic [1:0] sz
    );
        return NBYTES_LUT[sz];
    endfunction

endpackage

// File: rtl/packetmem_byte_extract.sv
// Big-endian byte extraction from a two-word window.
// Picks nbytes starting at off, zero-extended to 32 bits.
module packetmem_byte_extract
    import packetmem_rd_port_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  off,
    input  logic [1:0]  sz,
    output logic [31:0] result
);

    logic [31:0] win;
    logic        unused_tail;

    // The last byte of the window can never be requested.
    assign unused_tail = ^words[7:0];

    always_comb begin
        win = words[63:32];
        unique case (off)
            2'd0: win = words[63:32];
            2'd1: win = words[55:24];
            2'd2: win = words[47:16];
            2'd3: win = words[39:8];
            default: win = words[63:32];
        endcase
    end

    always_comb begin
        result = 32'h0;
        unique case (sz)
            SZ_WORD: result = win;
            SZ_HALF: result = {16'h0, win[31:16]};
            SZ_BYTE: result = {24'h0, win[31:24]};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/packetmem_rd_port.sv
// Packet-memory read responder: 1/2/4-byte big-endian loads.
// Macro PACKETMEM_RD_BOUNDS_CHECK_EN enables the packet_len check.
module packetmem_rd_port
    import packetmem_rd_port_pkg::*;
#(
    parameter int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2,
    parameter int PACKET_DATA_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_en,
    input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr,
    input  logic [1:0]                        transfer_sz,
    input  logic [31:0]                       packet_len,
    output logic                              rd_ready,
    output logic                              rd_valid,
    output logic [31:0]                       rd_data,
    output logic                              rd_err,
    output logic                              mem_rd_en,
    output logic [PACKET_ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic [PACKET_DATA_WIDTH-1:0]      mem_rd_data
);

    localparam int BW = PACKET_BYTE_ADDR_WIDTH;
    localparam int AW = PACKET_ADDR_WIDTH;

    state_e state_q, state_d;

    logic [BW-1:0] addr_q, addr_d;
    logic [1:0]    sz_q, sz_d;
    logic          span_q, span_d;
    logic          err_q, err_d;
    logic [31:0]   word0_q, word0_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic [2:0]    req_nbytes;
    logic          req_span;
    logic          req_rsvd;
    logic          req_oob;
    logic          req_bad;
    logic [AW-1:0] w0;
    logic [63:0]   ext_words;
    logic [31:0]   ext_result;

    assign req_nbytes = xfer_nbytes(transfer_sz);
    assign req_rsvd   = (transfer_sz == SZ_RSVD);
    assign req_span   = ({2'b00, byte_addr[1:0]}
                        + {1'b0, req_nbytes}) > 4'd4;

`ifdef PACKETMEM_RD_BOUNDS_CHECK_EN
    logic [32:0] req_end;

    // Widened so the end address can never wrap below packet_len.
    assign req_end = 33'(byte_addr) + 33'(req_nbytes);
    assign req_oob = req_end > {1'b0, packet_len};
`else
    logic unused_len;

    assign unused_len = ^packet_len;
    assign req_oob    = 1'b0;
`endif

    assign req_bad = req_rsvd | req_oob;
    assign w0      = addr_q[BW-1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    state_d = req_bad ? ST_RESP : ST_ISSUE0;
                end
            end
            ST_ISSUE0: state_d = ST_DATA0;
            ST_DATA0:  state_d = span_q ? ST_DATA1 : ST_RESP;
            ST_DATA1:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ready    = (state_q == ST_IDLE);
        rd_valid    = (state_q == ST_RESP);
        rd_err      = rd_valid & err_q;
        rd_data     = rd_data_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        unique case (state_q)
            ST_ISSUE0: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = w0;
            end
            ST_DATA0: begin
                mem_rd_en   = span_q;
                mem_rd_addr = span_q ? w0 + AW'(1) : '0;
            end
            default: begin
                mem_rd_en   = 1'b0;
                mem_rd_addr = '0;
            end
        endcase
    end

    // Non-spanning data sits in the upper word of the window.
    assign ext_words = (state_q == ST_DATA1)
                     ? {word0_q, mem_rd_data}
                     : {mem_rd_data, 32'h0};

    packetmem_byte_extract u_extract (
        .words  (ext_words),
        .off    (addr_q[1:0]),
        .sz     (sz_q),
        .result (ext_result)
    );

    always_comb begin
        addr_d    = addr_q;
        sz_d      = sz_q;
        span_d    = span_q;
        err_d     = err_q;
        word0_d   = word0_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    addr_d = byte_addr;
                    sz_d   = transfer_sz;
                    span_d = req_span;
                    err_d  = req_bad;
                    if (req_bad) begin
                        rd_data_d = 32'h0;
                    end
                end
            end
            ST_DATA0: begin
                if (span_q) begin
                    word0_d = mem_rd_data;
                end else begin
                    rd_data_d = ext_result;
                end
            end
            ST_DATA1: rd_data_d = ext_result;
            default: begin
                rd_data_d = rd_data_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            sz_q      <= 2'd0;
            span_q    <= 1'b0;
            err_q     <= 1'b0;
            word0_q   <= 32'h0;
            rd_data_q <= 32'h0;
        end else begin
            addr_q    <= addr_d;
            sz_q      <= sz_d;
            span_q    <= span_d;
            err_q     <= err_d;
            word0_q   <= word0_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_packetmem_rd_port.sv
// Scoreboard bench for packetmem_rd_port with a BRAM model.
// Honours PACKETMEM_RD_BOUNDS_CHECK_EN for the bounds cases.
module tb_packetmem_rd_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] byte_addr = 12'h0;
    logic [1:0]  transfer_sz = 2'd0;
    logic [31:0] packet_len = 32'h0;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nrd;
        logic [9:0]  a0;
        logic [9:0]  a1;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t_req = 0;
    int          rd_cnt = 0;
    int          rd_lat0 = 0;
    logic [9:0]  rd_a0 = 10'h0;
    logic [9:0]  rd_a1 = 10'h0;
    logic [31:0] mem [1024];
    logic [31:0] last_data = 32'h0;
    string       cur_tag = "none";

    packetmem_rd_port dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .byte_addr   (byte_addr),
        .transfer_sz (transfer_sz),
        .packet_len  (packet_len),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    // Byte-serial big-endian reference read with address wrap.
    function automatic logic [31:0] model(input logic [11:0] a,
                                          input logic [1:0] sz);
        logic [31:0] r;
        logic [11:0] b;
        logic [31:0] w;
        r = 32'h0;
        for (int k = 0; k < nbytes_of(sz); k++) begin
            b = a + 12'(k);
            w = mem[b[11:2]];
            r = {r[23:0], w[8*(3-int'(b[1:0])) +: 8]};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            rd_cnt = 0;
        end else begin
            if (mem_rd_en) begin
                if (rd_cnt == 0) begin
                    rd_a0   = mem_rd_addr;
                    rd_lat0 = cyc - t_req + 1;
                end else begin
                    rd_a1 = mem_rd_addr;
                end
                rd_cnt++;
            end
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk({cur_tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({cur_tag, "_data"}, rd_data, e.data);
                    chk({cur_tag, "_err"}, 32'(rd_err), 32'(e.err));
                    chk({cur_tag, "_lat"}, 32'(cyc - t_req + 1),
                        32'(e.lat));
                    chk({cur_tag, "_nrd"}, 32'(rd_cnt), 32'(e.nrd));
                    if (e.nrd > 0 && rd_cnt > 0) begin
                        chk({cur_tag, "_a0"}, 32'(rd_a0), 32'(e.a0));
                        chk({cur_tag, "_rdlat"}, 32'(rd_lat0), 32'd1);
                    end
                    if (e.nrd > 1 && rd_cnt > 1) begin
                        chk({cur_tag, "_a1"}, 32'(rd_a1), 32'(e.a1));
                    end
                end
                rd_cnt = 0;
            end
        end
    end

    task automatic req(input string tag,
                       input logic [11:0] a,
                       input logic [1:0] sz,
                       input logic [31:0] plen,
                       input logic [31:0] ed,
                       input logic ee,
                       input bit pulse);
        exp_t e;
        int   nb;
        int   off;
        int   n;
        nb = nbytes_of(sz);
        off = int'(a[1:0]);
        e.data = ed;
        e.err = ee;
        if (ee) begin
            e.lat = 1;
            e.nrd = 0;
        end else begin
            e.lat = (off + nb > 4) ? 4 : 3;
            e.nrd = (off + nb > 4) ? 2 : 1;
        end
        e.a0 = a[11:2];
        e.a1 = a[11:2] + 10'd1;
        @(posedge clk);
        #1;
        cur_tag = tag;
        chk({tag, "_ready"}, 32'(rd_ready), 32'd1);
        chk({tag, "_hold"}, rd_data, last_data);
        sb.push_back(e);
        rd_en = 1'b1;
        byte_addr = a;
        transfer_sz = sz;
        packet_len = plen;
        @(posedge clk);
        #1;
        t_req = cyc;
        rd_en = 1'b0;
        if (pulse) begin
            @(posedge clk);
            #1 rd_en = 1'b1;
            byte_addr = 12'h0;
            transfer_sz = 2'd3;
            @(posedge clk);
            #1 rd_en = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(sb.size()), 32'd0);
        sb.delete();
        last_data = ed;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(rd_ready), 32'd1);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_err"}, 32'(rd_err), 32'd0);
        chk({tag, "_data"}, rd_data, 32'd0);
        chk({tag, "_memen"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_memaddr"}, 32'(mem_rd_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [11:0] a;
        logic [1:0]  s;
        logic [31:0] plen;
        logic        e;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'hDEADBEEF;
        #2;
        chk_reset("rst0");
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        req("aligned", 12'd4, 2'd0, 32'd64, 32'hDEADBEEF, 1'b0, 1'b0);
        mem[1] = 32'h55667788;
        req("span_half", 12'd3, 2'd1, 32'd64, 32'h00004455, 1'b0, 1'b1);
        req("byte", 12'd6, 2'd2, 32'd64, 32'h00000077, 1'b0, 1'b0);
        req("half", 12'd2, 2'd1, 32'd64, 32'h00003344, 1'b0, 1'b0);
`ifdef PACKETMEM_RD_BOUNDS_CHECK_EN
        req("oob", 12'd4, 2'd0, 32'd6, 32'h0, 1'b1, 1'b0);
`else
        req("oob", 12'd4, 2'd0, 32'd6, 32'h55667788, 1'b0, 1'b0);
`endif
        req("exact_end", 12'd2, 2'd0, 32'd6, 32'h33445566, 1'b0, 1'b0);
        req("rsvd", 12'd0, 2'd3, 32'd64, 32'h0, 1'b1, 1'b0);
        req("wrap", 12'hFFF, 2'd1, 32'd5000,
            model(12'hFFF, 2'd1), 1'b0, 1'b0);

        // Abort a spanning read in DATA0.
        @(posedge clk);
        #1;
        cur_tag = "abort";
        rd_en = 1'b1;
        byte_addr = 12'd3;
        transfer_sz = 2'd1;
        packet_len = 32'd64;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_reset("abort_rst");
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_ready", 32'(rd_ready), 32'd1);
        last_data = 32'h0;
        req("after_abort", 12'd3, 2'd1, 32'd64,
            32'h00004455, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a = 12'($urandom_range(0, 4095));
            s = 2'($urandom_range(0, 2));
`ifdef PACKETMEM_RD_BOUNDS_CHECK_EN
            plen = 32'($urandom_range(0, 4200));
            e = (longint'(a) + longint'(nbytes_of(s))) > longint'(plen);
`else
            plen = $urandom;
            e = 1'b0;
`endif
            req("rnd", a, s, plen, e ? 32'h0 : model(a, s), e, 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
